pal_line_scheduler: RTL and testbench

//  Frame-level sequencer for NTSC->PAL conversion. Counts VDG lines from FSn,
//  at a fixed line stalls the VDG and emits synthetic padding lines, stretching
//  the frame to PAL length. Owns the frame format latch (PAL-stretch vs

---
 rtl/pal_sched_pkg.sv | 16 +
 rtl/sync_edge.sv | 30 +++
 rtl/pal_line_scheduler.sv | 160 ++++++++++++++++
 tb/tb_pal_line_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_sched_pkg.sv
// Shared types and reset constants for the NTSC->PAL line scheduler.
package pal_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        INSERT = 2'd2,
        DONE   = 2'd3
    } sched_state_e;

    localparam int           SYNC_STAGES    = 2;
    localparam sched_state_e RST_STATE      = IDLE;
    localparam logic         RST_FRM_FORMAT = 1'b1;
    localparam logic         RST_PERIOD_ERR = 1'b0;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous active-low strobe and produces single-cycle
// rise/fall pulses, two cycles after the sync chain settles.
module sync_edge
    import pal_sched_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Idle level of the sync strobes is high, so reset to 1 to avoid a false fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = ~prev_q & sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pal_line_scheduler.sv
// Frame sequencer: counts VDG lines and, in PAL-stretch mode, stalls the VDG
// at a fixed line while emitting synthetic padding lines.
//
// state  | meaning
// IDLE   | waiting for first FSn fall after reset
// COUNT  | counting VDG lines, watching for the insertion line
// INSERT | VDG held, synthetic lines being emitted
// DONE   | insertion finished, waiting for next FSn fall
module pal_line_scheduler
    import pal_sched_pkg::*;
#(
    parameter int LINE_W      = 9,
    parameter int CYC_W       = 10,
    parameter int START_LINE  = 24,
    parameter int EXTRA_LINES = 50,
    parameter int HS_WIDTH    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hsn_i,
    input  logic              fsn_i,
    input  logic              format_i,
    output logic              hold_o,
    output logic              ins_hsn_o,
    output logic              frm_format_o,
    output logic [LINE_W-1:0] line_o,
    output logic              period_err_o
);

    localparam logic [LINE_W-1:0] LINE_MAX = '1;
    localparam logic [CYC_W-1:0]  CYC_MAX  = '1;
    localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);

    sched_state_e      state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d, line_inc;
    logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;
    logic [CYC_W-1:0]  period_q, period_d;
    logic [CYC_W-1:0]  tmr_q, tmr_d, hs_thr;
    logic [LINE_W-1:0] lines_left_q, lines_left_d;
    logic              frm_format_q, frm_format_d;
    logic              period_err_q, period_err_d;
    logic              hs_fall, hs_rise_unused, fs_fall, fs_rise;
    logic              period_valid, hit_start;

    sync_edge u_sync_hs (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(hsn_i),
        .rise_o (hs_rise_unused),
        .fall_o (hs_fall)
    );

    sync_edge u_sync_fs (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(fsn_i),
        .rise_o (fs_rise),
        .fall_o (fs_fall)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RST_STATE;
            line_q       <= '0;
            cyc_q        <= '0;
            period_q     <= '0;
            tmr_q        <= '0;
            lines_left_q <= '0;
            frm_format_q <= RST_FRM_FORMAT;
            period_err_q <= RST_PERIOD_ERR;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            cyc_q        <= cyc_d;
            period_q     <= period_d;
            tmr_q        <= tmr_d;
            lines_left_q <= lines_left_d;
            frm_format_q <= frm_format_d;
            period_err_q <= period_err_d;
        end
    end

    assign line_inc     = (line_q == LINE_MAX) ? line_q : line_q + LINE_W'(1);
    assign cyc_inc      = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_ONE;
    assign period_valid = (period_q != '0) && (period_q != CYC_MAX);
    assign hit_start    = hs_fall && !fs_fall && (line_inc == LINE_W'(START_LINE));

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        cyc_d        = cyc_q;
        period_d     = period_q;
        tmr_d        = tmr_q;
        lines_left_d = lines_left_q;
        frm_format_d = frm_format_q;
        period_err_d = period_err_q;

        if (fs_rise) frm_format_d = format_i;

        // Period is measured in VDG time, so the counter freezes while the VDG is held.
        if (state_q != INSERT) begin
            if (hs_fall) begin
                period_d = cyc_inc;
                cyc_d    = '0;
            end else begin
                cyc_d = cyc_inc;
            end
        end

        if (fs_fall)                           line_d = '0;
        else if (hs_fall && state_q != INSERT) line_d = line_inc;

        case (state_q)
            IDLE:   if (fs_fall) state_d = COUNT;
            COUNT: begin
                if (hit_start && !frm_format_q) begin
                    if (period_valid) begin
                        state_d      = INSERT;
                        tmr_d        = period_q - CYC_ONE;
                        lines_left_d = LINE_W'(EXTRA_LINES - 1);
                    end else begin
                        period_err_d = 1'b1;
                    end
                end
            end
            INSERT: begin
                if (fs_fall) begin
                    state_d = COUNT;
                end else if (tmr_q == '0) begin
                    if (lines_left_q == '0) begin
                        state_d = DONE;
                    end else begin
                        lines_left_d = lines_left_q - LINE_W'(1);
                        tmr_d        = period_q - CYC_ONE;
                    end
                end else begin
                    tmr_d = tmr_q - CYC_ONE;
                end
            end
            DONE:    if (fs_fall) state_d = COUNT;
            default: state_d = IDLE;
        endcase
    end

    // Line timer counts down, so sync is low while the timer is at or above hs_thr.
    always_comb begin
        hs_thr    = (HS_WIDTH >= int'(period_q)) ? CYC_ONE : period_q - CYC_W'(HS_WIDTH);
        hold_o    = 1'b0;
        ins_hsn_o = 1'b1;
        if (state_q == INSERT) begin
            hold_o    = 1'b1;
            ins_hsn_o = !(tmr_q >= hs_thr);
        end
    end

    assign frm_format_o = frm_format_q;
    assign line_o       = line_q;
    assign period_err_o = period_err_q;

endmodule

// File: tb/tb_pal_line_scheduler.sv
// Self-checking bench for pal_line_scheduler: table of frame scenarios plus
// hand-written abort, reset, format-latch and latency sequences.
`timescale 1ns/1ps
module tb_pal_line_scheduler;

    logic       clk = 1'b0;
    logic       rst_i, hsn_i, fsn_i, format_i;
    logic       hold_o, ins_hsn_o, frm_format_o, period_err_o;
    logic [8:0] line_o;

    always #5 clk = ~clk;

    pal_line_scheduler dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .hsn_i       (hsn_i),
        .fsn_i       (fsn_i),
        .format_i    (format_i),
        .hold_o      (hold_o),
        .ins_hsn_o   (ins_hsn_o),
        .frm_format_o(frm_format_o),
        .line_o      (line_o),
        .period_err_o(period_err_o)
    );

    typedef struct {
        int hold_len;
        int pulses;
        int pulse_len;
    } ins_exp_t;

    typedef struct {
        logic fmt;
        int   short_gap;
        int   long_gap;
        bit   ins;
        int   hold_len;
        int   pulses;
        int   pulse_len;
        logic perr;
    } vec_t;

    ins_exp_t sb_q[$];
    vec_t     vecs[4];

    int checks = 0;
    int passes = 0;
    int hold_total = 0;
    int m_hold_len, m_pulses, m_low, m_min, m_max;
    bit prev_hold, prev_ins;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        m_hold_len = 0;
        m_pulses   = 0;
        m_low      = 0;
        m_min      = 1 << 30;
        m_max      = 0;
    endtask

    // Measures each HOLD burst and checks it against the next queued expectation.
    task automatic monitor();
        ins_exp_t e;
        mon_clear();
        prev_hold = 1'b0;
        prev_ins  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                mon_clear();
                prev_hold = 1'b0;
                prev_ins  = 1'b1;
            end else begin
                if (hold_o) begin
                    hold_total++;
                    m_hold_len++;
                    if (!ins_hsn_o) begin
                        if (prev_ins) m_pulses++;
                        m_low++;
                    end else if (!prev_ins) begin
                        if (m_low < m_min) m_min = m_low;
                        if (m_low > m_max) m_max = m_low;
                        m_low = 0;
                    end
                end else if (prev_hold) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_hold_len", m_hold_len, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("hold_len", m_hold_len, e.hold_len);
                        check("ins_pulses", m_pulses, e.pulses);
                        check("pulse_len_min", m_min, e.pulse_len);
                        check("pulse_len_max", m_max, e.pulse_len);
                    end
                    mon_clear();
                end
                prev_hold = hold_o;
                prev_ins  = ins_hsn_o;
            end
        end
    endtask

    task automatic fs_pulse(logic fmt);
        format_i = fmt;
        fsn_i    = 1'b0;
        tick(6);
        fsn_i = 1'b1;
        tick(6);
    endtask

    // Lines 1..23 with the given fall-to-fall gaps; the 24th fall is left low.
    task automatic drive_lines(int short_gap, int long_gap);
        for (int i = 1; i < 24; i++) begin
            hsn_i = 1'b0;
            tick(8);
            hsn_i = 1'b1;
            tick(((i >= 22) ? long_gap : short_gap) - 8);
        end
        hsn_i = 1'b0;
    endtask

    task automatic wait_hold_low(int limit);
        int n = 0;
        while (hold_o !== 1'b1 && n < limit) begin tick(1); n++; end
        while (hold_o === 1'b1 && n < limit) begin tick(1); n++; end
        tick(2);
        check("hold_wait_in_budget", int'(n < limit), 1);
    endtask

    task automatic wait_hold_high(string name, int limit);
        int n = 0;
        while (hold_o !== 1'b1 && n < limit) begin tick(1); n++; end
        check(name, hold_o, 1);
    endtask

    initial begin
        int hold_mark;
        vecs[0] = '{1'b0, 40, 1100, 1'b0, 0,     0,  0,  1'b1};
        vecs[1] = '{1'b0, 40, 910,  1'b1, 45500, 50, 64, 1'b1};
        vecs[2] = '{1'b1, 40, 300,  1'b0, 0,     0,  0,  1'b1};
        vecs[3] = '{1'b0, 40, 50,   1'b1, 2500,  50, 49, 1'b1};

        rst_i    = 1'b1;
        hsn_i    = 1'b1;
        fsn_i    = 1'b1;
        format_i = 1'b0;
        fork monitor(); join_none
        tick(3);
        check("rst_hold", hold_o, 0);
        check("rst_ins_hsn", ins_hsn_o, 1);
        check("rst_frm_format", frm_format_o, 1);
        check("rst_line", line_o, 0);
        check("rst_period_err", period_err_o, 0);
        rst_i = 1'b0;
        tick(3);

        for (int v = 0; v < 4; v++) begin
            fs_pulse(vecs[v].fmt);
            check("line_after_fs", line_o, 0);
            check("frm_format_latch", frm_format_o, vecs[v].fmt);
            hold_mark = hold_total;
            drive_lines(vecs[v].short_gap, vecs[v].long_gap);
            tick(8);
            hsn_i = 1'b1;
            if (vecs[v].ins) begin
                sb_q.push_back('{vecs[v].hold_len, vecs[v].pulses, vecs[v].pulse_len});
                tick(100);
                hsn_i = 1'b0;
                tick(8);
                hsn_i = 1'b1;
                wait_hold_low(vecs[v].hold_len + 200);
            end else begin
                tick(50);
            end
            check("hold_cycles", hold_total - hold_mark, vecs[v].ins ? vecs[v].hold_len : 0);
            check("line_stays_24", line_o, 24);
            check("period_err", period_err_o, vecs[v].perr);
        end

        // Format changes mid-frame only take effect at the next FSn rise.
        fs_pulse(1'b1);
        check("frm_fmt1", frm_format_o, 1);
        format_i = 1'b0;
        tick(20);
        check("frm_midframe", frm_format_o, 1);
        fsn_i = 1'b0;
        tick(6);
        check("frm_at_fs_fall", frm_format_o, 1);
        fsn_i = 1'b1;
        tick(2);
        check("frm_rise_2cyc", frm_format_o, 1);
        tick(1);
        check("frm_rise_3cyc", frm_format_o, 0);
        tick(6);

        // Simultaneous FSn/HSn fall, then exact 3-cycle edge latency.
        for (int i = 0; i < 3; i++) begin
            hsn_i = 1'b0;
            tick(8);
            hsn_i = 1'b1;
            tick(32);
        end
        check("line_pre_same", line_o, 3);
        fsn_i = 1'b0;
        hsn_i = 1'b0;
        tick(3);
        check("fs_hs_same_cycle", line_o, 0);
        tick(5);
        fsn_i = 1'b1;
        hsn_i = 1'b1;
        tick(10);
        hsn_i = 1'b0;
        tick(2);
        check("latency_2cyc", line_o, 0);
        tick(1);
        check("latency_3cyc", line_o, 1);
        hsn_i = 1'b1;
        tick(10);

        // Abort 10000 cycles into INSERT; 300-cycle lines.
        fs_pulse(1'b0);
        drive_lines(40, 300);
        sb_q.push_back('{10003, 34, 64});
        wait_hold_high("abort_hold_rise", 20);
        tick(10000);
        fsn_i = 1'b0;
        tick(2);
        check("abort_hold_still_2cyc", hold_o, 1);
        tick(1);
        check("abort_hold", hold_o, 0);
        check("abort_ins_hsn", ins_hsn_o, 1);
        check("abort_line", line_o, 0);
        tick(4);
        fsn_i = 1'b1;
        tick(6);
        hsn_i = 1'b1;
        tick(10);

        // Next frame inserts again; reset lands in the middle of it.
        fs_pulse(1'b0);
        drive_lines(40, 300);
        wait_hold_high("next_frame_insert", 20);
        tick(500);
        check("pre_rst_hold", hold_o, 1);
        check("pre_rst_line", line_o, 24);
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_hold", hold_o, 0);
        check("rst_mid_ins_hsn", ins_hsn_o, 1);
        check("rst_mid_line", line_o, 0);
        check("rst_mid_frm", frm_format_o, 1);
        check("rst_mid_perr", period_err_o, 0);
        hsn_i = 1'b1;
        tick(3);
        rst_i = 1'b0;
        tick(5);
        check("post_rst_hold", hold_o, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
